// File: rtl/mips_mem_pkg.sv
// Shared definitions for the M-stage data-bus bridge: FSM state encodings,
// default error read data and address alignment helpers.
package mips_mem_pkg;

  // FSM state encodings (kept as plain constants for legacy tool flows)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Value handed back to the core when the slave never answers
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  // Low address bits that must be zero for a word access
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // True when the byte address points at a word boundary
  function automatic logic is_aligned(input logic [31:0] addr);
    return ((addr[1:0] & ALIGN_MASK) == 2'b00);
  endfunction

  // Word address presented on the bus (byte offset forced to zero)
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Bus wait counter: counts BUSY cycles without an ack and flags when the
// last permitted cycle has been reached.
module bus_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  // Count value of the final permitted wait cycle
  localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

  logic [7:0] r_cnt;

  // Clear on a new transaction, otherwise count enabled cycles (saturating)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == LIMIT_M1);

endmodule

// File: rtl/data_mem_bridge.sv
// Memory-stage data-bus bridge: turns the core's single-cycle M-stage access
// into a req/ack bus transaction and stalls the pipeline until it completes,
// is rejected as misaligned, or times out.
module data_mem_bridge
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  logic [1:0]  r_state;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_readdata;
  logic        r_mem_err;
  logic        r_is_read;   // pure load: return bus data
  logic        r_rd_zero;   // load+store collision: return zero

  logic        w_access;
  logic        w_aligned;
  logic        w_issue;
  logic        w_misalign;
  logic        w_ack_busy;
  logic        w_timeout;
  logic        w_cnt_en;
  logic        w_expired;
  logic [1:0]  w_state_nxt;

  bus_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo (
    .clk       (clk),
    .rst_n     (rst),
    .i_clr     (w_issue),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  // Next-state and event decode for the IDLE/BUSY/DONE sequencer
  always_comb begin
    w_access    = memreadM | memwriteM;
    w_aligned   = is_aligned(aluoutM);
    w_issue     = 1'b0;
    w_misalign  = 1'b0;
    w_ack_busy  = (r_state == ST_BUSY) & bus_ack;
    w_timeout   = (r_state == ST_BUSY) & ~bus_ack & w_expired;
    w_cnt_en    = (r_state == ST_BUSY) & ~bus_ack;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_aligned) begin
            w_issue     = 1'b1;
            w_state_nxt = ST_BUSY;
          end else begin
            w_misalign  = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_ack_busy || w_timeout) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus request: raised on issue, dropped on ack or abort (or reset)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_req <= 1'b0;
    end else if (w_issue) begin
      r_bus_req <= 1'b1;
    end else if (w_ack_busy || w_timeout) begin
      r_bus_req <= 1'b0;
    end else begin
      r_bus_req <= r_bus_req;
    end
  end

  // Transaction attributes latched at issue and held for the slave
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_is_read   <= 1'b0;
      r_rd_zero   <= 1'b0;
    end else if (w_issue) begin
      r_bus_we    <= memwriteM;
      r_bus_addr  <= word_addr(aluoutM);
      r_bus_wdata <= writedataM;
      r_is_read   <= memreadM & ~memwriteM;
      r_rd_zero   <= memreadM & memwriteM;
    end else begin
      r_bus_we    <= r_bus_we;
      r_bus_addr  <= r_bus_addr;
      r_bus_wdata <= r_bus_wdata;
      r_is_read   <= r_is_read;
      r_rd_zero   <= r_rd_zero;
    end
  end

  // Load data to the core: updated only when an access finishes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_readdata <= 32'd0;
    end else if (w_misalign) begin
      r_readdata <= 32'd0;
    end else if (w_timeout) begin
      r_readdata <= ERR_RDATA;
    end else if (w_ack_busy && r_is_read) begin
      r_readdata <= bus_rdata;
    end else if (w_ack_busy && r_rd_zero) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= r_readdata;
    end
  end

  // Single-cycle error pulse for misalignment or bus timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_misalign | w_timeout;
    end
  end

  // Stall is combinational so the core freezes in the same cycle it asks;
  // it is forced low while reset is held.
  assign stallM    = w_access & (r_state != ST_DONE) & rst;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign readdataM = r_readdata;
  assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: transaction-level reference model,
// directed scenarios plus randomized loads/stores/misaligns/timeouts.
module tb_data_mem_bridge;

  localparam int unsigned TO   = 4;
  localparam logic [31:0] ERRV = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM;
  logic [31:0] aluoutM, writedataM, readdataM;
  logic        stallM, mem_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;

  always #5 clk = ~clk;

  data_mem_bridge #(.TIMEOUT_CYC(TO), .ERR_RDATA(ERRV)) dut (
    .clk(clk), .rst(rst), .memreadM(memreadM), .memwriteM(memwriteM),
    .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
    .stallM(stallM), .mem_err(mem_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // expected outputs for the current cycle
  logic        e_stall, e_req, e_err, e_we;
  logic [31:0] e_rd, e_addr, e_wdata;
  // model of the last completed results
  logic        m_we = 1'b0;
  logic [31:0] m_rd = 32'd0, m_addr = 32'd0, m_wdata = 32'd0;
  // per-transaction observation counters
  int obs_stall, obs_req, obs_err;

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stallM",    32'(stallM),  32'(e_stall));
      cmp("bus_req",   32'(bus_req), 32'(e_req));
      cmp("mem_err",   32'(mem_err), 32'(e_err));
      cmp("readdataM", readdataM,    e_rd);
      cmp("bus_we",    32'(bus_we),  32'(e_we));
      cmp("bus_addr",  bus_addr,     e_addr);
      cmp("bus_wdata", bus_wdata,    e_wdata);
      obs_stall += int'(stallM);
      obs_req   += int'(bus_req);
      obs_err   += int'(mem_err);
    end
  end

  task automatic set_hold_exp();
    e_rd = m_rd; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
  endtask

  task automatic idle_cycle(input logic stray);
    @(posedge clk); #1;
    memreadM = 1'b0; memwriteM = 1'b0;
    aluoutM = $urandom; writedataM = $urandom;
    bus_ack = stray; bus_rdata = $urandom;
    e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0;
    set_hold_exp();
  endtask

  // One core access: ack_at = BUSY cycle carrying the ack (0 or >TO: none)
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata);
    int nb;
    logic aligned, tmo;
    aligned = (addr[1:0] == 2'b00);
    if (!aligned) begin nb = 0; tmo = 1'b0; end
    else if (ack_at >= 1 && ack_at <= int'(TO)) begin nb = ack_at; tmo = 1'b0; end
    else begin nb = int'(TO); tmo = 1'b1; end
    obs_stall = 0; obs_req = 0; obs_err = 0;
    for (int k = 0; k <= nb + 1; k++) begin
      @(posedge clk); #1;
      if (k <= nb) begin
        memreadM = rd; memwriteM = wr; aluoutM = addr; writedataM = wdata;
      end else begin
        memreadM = 1'b0; memwriteM = 1'b0; aluoutM = $urandom; writedataM = $urandom;
      end
      bus_rdata = $urandom;
      bus_ack = 1'b0;
      if (k == 0 || k == nb + 1) bus_ack = 1'($urandom_range(0, 1));  // stray, must be ignored
      if (!tmo && aligned && k == nb) begin bus_ack = 1'b1; bus_rdata = rdata; end
      if (k == 1 && aligned) begin
        m_we = wr; m_addr = {addr[31:2], 2'b00}; m_wdata = wdata;
      end
      if (k == nb + 1) begin
        if (!aligned)          m_rd = 32'd0;
        else if (tmo)          m_rd = ERRV;
        else if (rd && !wr)    m_rd = rdata;
        else if (rd && wr)     m_rd = 32'd0;
      end
      e_stall = (k <= nb);
      e_req   = (k >= 1 && k <= nb);
      e_err   = (k == nb + 1) && (!aligned || tmo);
      set_hold_exp();
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra, rw, rr, rb;
    int kind, gap;
    rst = 1'b0; memreadM = 1'b1; memwriteM = 1'b0; aluoutM = 32'd0; writedataM = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    #1;
    cmp("rst_stallM",    32'(stallM),  32'd0);
    cmp("rst_bus_req",   32'(bus_req), 32'd0);
    cmp("rst_readdataM", readdataM,    32'd0);
    cmp("rst_bus_addr",  bus_addr,     32'd0);
    cmp("rst_mem_err",   32'(mem_err), 32'd0);
    memreadM = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0; set_hold_exp();
    chk_en = 1'b1;
    idle_cycle(1'b1);

    // 1: load, ack on 3rd BUSY cycle
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'd0, 3, 32'h1234_5678); settle();
    cmp("t1_stall_cycles", 32'(obs_stall), 32'd4);
    cmp("t1_readdata",     readdataM,      32'h1234_5678);
    cmp("t1_bus_we",       32'(bus_we),    32'd0);
    cmp("t1_err_count",    32'(obs_err),   32'd0);

    // 2: store, ack next cycle
    run_txn(1'b0, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 1, 32'd0); settle();
    cmp("t2_stall_cycles", 32'(obs_stall), 32'd2);
    cmp("t2_bus_we",       32'(bus_we),    32'd1);
    cmp("t2_bus_addr",     bus_addr,       32'h0000_0104);
    cmp("t2_bus_wdata",    bus_wdata,      32'hCAFE_F00D);

    // 3: misaligned load
    run_txn(1'b1, 1'b0, 32'h0000_0102, 32'd0, 1, 32'd0); settle();
    cmp("t3_stall_cycles", 32'(obs_stall), 32'd1);
    cmp("t3_req_cycles",   32'(obs_req),   32'd0);
    cmp("t3_err_count",    32'(obs_err),   32'd1);
    cmp("t3_readdata",     readdataM,      32'd0);

    // 4: load with no ack -> timeout, then stray acks ignored
    run_txn(1'b1, 1'b0, 32'h0000_0080, 32'd0, 0, 32'd0); settle();
    cmp("t4_req_cycles",   32'(obs_req),   32'd4);
    cmp("t4_readdata",     readdataM,      32'hDEADBEEF);
    cmp("t4_err_count",    32'(obs_err),   32'd1);
    idle_cycle(1'b1); idle_cycle(1'b1); idle_cycle(1'b0);

    // ack on the exact timeout cycle wins
    run_txn(1'b1, 1'b0, 32'h0000_0090, 32'd0, 4, 32'h0BAD_F00D); settle();
    cmp("tx_err_count",    32'(obs_err),   32'd0);
    cmp("tx_readdata",     readdataM,      32'h0BAD_F00D);

    // 5: back-to-back loads, ack 1 cycle each
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1, 32'h1111_1111);
    run_txn(1'b1, 1'b0, 32'h0000_0014, 32'd0, 1, 32'h2222_2222); settle();
    cmp("t5_req_cycles",   32'(obs_req),   32'd1);
    cmp("t5_readdata",     readdataM,      32'h2222_2222);

    // load+store collision: write wins, load data forced to zero
    run_txn(1'b1, 1'b1, 32'h0000_0020, 32'h5555_AAAA, 2, 32'h7777_7777); settle();
    cmp("tc_bus_we",       32'(bus_we),    32'd1);
    cmp("tc_readdata",     readdataM,      32'd0);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      ra = $urandom; rw = $urandom; rr = $urandom; rb = $urandom;
      if (rb[2:0] != 3'd0) ra[1:0] = 2'b00;
      kind = int'($urandom_range(0, 2));
      run_txn(kind != 1, kind != 0, ra, rw, int'($urandom_range(0, 5)), rr);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle_cycle(rb[8 + g]);
    end

    // reset in the middle of a BUSY phase
    idle_cycle(1'b0);
    @(posedge clk); #1;
    memreadM = 1'b1; aluoutM = 32'h0000_0200; bus_ack = 1'b0;
    e_stall = 1'b1; e_req = 1'b0; e_err = 1'b0; set_hold_exp();
    @(posedge clk); #1;
    chk_en = 1'b0;
    cmp("pre_rst_bus_req", 32'(bus_req), 32'd1);
    rst = 1'b0; #1;
    cmp("mid_rst_bus_req",   32'(bus_req), 32'd0);
    cmp("mid_rst_stallM",    32'(stallM),  32'd0);
    cmp("mid_rst_readdataM", readdataM,    32'd0);
    cmp("mid_rst_bus_addr",  bus_addr,     32'd0);
    memreadM = 1'b0;
    m_rd = 32'd0; m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
    @(posedge clk); #1; rst = 1'b1;
    e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0; set_hold_exp();
    chk_en = 1'b1;
    run_txn(1'b1, 1'b0, 32'h0000_0300, 32'd0, 2, 32'hA5A5_5A5A); settle();
    cmp("post_rst_stall_cycles", 32'(obs_stall), 32'd3);
    cmp("post_rst_readdata",     readdataM,      32'hA5A5_5A5A);
    idle_cycle(1'b0);
    settle();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
